// File: rtl/bram_chk_pkg.sv
// Shared definitions for the BRAM march checker: FSM states, test modes, patterns.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package bram_chk_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WRITE,
    READ,
    M0,
    M1,
    M2,
    M3,
    M4,
    M5,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'b00,
    MODE_CHECKER = 2'b01,
    MODE_ADDR    = 2'b10,
    MODE_MARCH   = 2'b11
  } mode_t;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  // Alternating 10... pattern, low w bits valid; callers truncate to their word width.
  function automatic logic [31:0] pat_a(input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return 32'hAAAA_AAAA & m;
  endfunction

  // Bitwise complement of pat_a within the low w bits.
  function automatic logic [31:0] pat_b(input int unsigned w);
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return 32'h5555_5555 & m;
  endfunction

endpackage

// File: rtl/bram_sp.sv
// Single-port inferred block RAM, read-first, registered output.
// Latency: dout valid one cycle after addr is presented.
// Backpressure: none; accepts one access every cycle.
module bram_sp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Read-first port: dout returns the word held before this cycle's write.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/bram_march_checker.sv
// BRAM self-test: fill with a pattern (or run March C-), read back, count mismatches.
// Latency: done at 2D+2 edges after start (modes 00-10), 10D+2 edges (March C-).
// Backpressure: start is ignored while busy; no other flow control.
module bram_march_checker
  import bram_chk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              inject_en,
  input  logic [ADDR_W-1:0] inject_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        leds
);

  localparam logic [DATA_W-1:0] P_A  = DATA_W'(pat_a(DATA_W));
  localparam logic [DATA_W-1:0] P_B  = DATA_W'(pat_b(DATA_W));
  localparam logic [DATA_W-1:0] ZERO = '0;
  localparam logic [DATA_W-1:0] ONES = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ph_q, ph_d;          // read-write elements: 0 = read, 1 = compare+write

  mode_t             mode_q;
  logic              inj_armed_q;
  logic [ADDR_W-1:0] inj_addr_q;
  logic              fail;

  logic              we;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rd_issue;
  logic [DATA_W-1:0] rd_exp;

  logic              cmp_vld_q;
  logic [DATA_W-1:0] cmp_exp_q;
  logic [ADDR_W-1:0] cmp_addr_q;

  logic              elem_inv, elem_down, elem_last;
  logic              inj_hit, mismatch, err_zero_final;
  logic [4:0]        err_sat;

  function automatic logic [DATA_W-1:0] fill_pat(input mode_t m, input logic [ADDR_W-1:0] a);
    case (m)
      MODE_CHECKER: return a[0] ? P_B : P_A;
      MODE_ADDR:    return DATA_W'(a);
      default:      return P_A;
    endcase
  endfunction

  // M2/M4 expect ones and write zeros; M3/M4 walk the address space downward.
  assign elem_inv  = (state_q == M2) || (state_q == M4);
  assign elem_down = (state_q == M3) || (state_q == M4);
  assign elem_last = elem_down ? ~|addr_q : &addr_q;

  // Only the first write to the armed address is corrupted.
  assign inj_hit = we && inj_armed_q && (addr_q == inj_addr_q);
  assign din     = wdat ^ {{(DATA_W-1){1'b0}}, inj_hit};

  assign mismatch       = cmp_vld_q && (dout != cmp_exp_q);
  assign err_zero_final = (err_count == 16'd0) && !mismatch;

  assign busy    = (state_q != IDLE);
  assign err_sat = (err_count > 16'd31) ? 5'd31 : err_count[4:0];
  assign leds    = {busy, pass, fail, err_sat};

  bram_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .we   (we),
    .addr (addr_q),
    .din  (din),
    .dout (dout)
  );

  // Sequencer state, address counter and read/write phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
    end
  end

  // Next state, address stepping and RAM access for the current element.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ph_d     = ph_q;
    we       = 1'b0;
    wdat     = '0;
    rd_issue = 1'b0;
    rd_exp   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (mode_t'(mode) == MODE_MARCH) ? M0 : WRITE;
          addr_d  = '0;
          ph_d    = 1'b0;
        end
      end
      WRITE: begin
        we   = 1'b1;
        wdat = fill_pat(mode_q, addr_q);
        if (elem_last) begin
          state_d = READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      READ: begin
        rd_issue = 1'b1;
        rd_exp   = fill_pat(mode_q, addr_q);
        if (elem_last) state_d = DRAIN;
        else           addr_d  = addr_q + 1'b1;
      end
      M0: begin
        we   = 1'b1;
        wdat = ZERO;
        if (elem_last) begin
          state_d = M1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      M1, M2, M3, M4: begin
        if (!ph_q) begin
          rd_issue = 1'b1;
          rd_exp   = elem_inv ? ONES : ZERO;
          ph_d     = 1'b1;
        end else begin
          we   = 1'b1;
          wdat = elem_inv ? ZERO : ONES;
          ph_d = 1'b0;
          if (elem_last) begin
            case (state_q)
              M1:      state_d = M2;
              M2:      state_d = M3;
              M3:      state_d = M4;
              default: state_d = M5;
            endcase
            addr_d = ((state_q == M2) || (state_q == M3)) ? '1 : '0;
          end else begin
            addr_d = elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
      end
      M5: begin
        rd_issue = 1'b1;
        rd_exp   = ZERO;
        if (elem_last) state_d = DRAIN;
        else           addr_d  = addr_q + 1'b1;
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Run configuration latch, compare pipeline and result/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= MODE_SOLID;
      inj_armed_q <= 1'b0;
      inj_addr_q  <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      err_count   <= '0;
      fail_addr   <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done       <= 1'b0;
      cmp_vld_q  <= rd_issue;
      cmp_exp_q  <= rd_exp;
      cmp_addr_q <= addr_q;
      if (inj_hit) inj_armed_q <= 1'b0;
      if (state_q == IDLE && start) begin
        mode_q      <= mode_t'(mode);
        inj_armed_q <= inject_en;
        inj_addr_q  <= inject_addr;
        err_count   <= '0;
        fail_addr   <= '0;
        pass        <= 1'b0;
        fail        <= 1'b0;
      end
      if (mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + 16'd1;
        if (err_count == 16'd0)   fail_addr <= cmp_addr_q;
      end
      if (state_q == DRAIN) begin
        done <= 1'b1;
        pass <= err_zero_final;
        fail <= ~err_zero_final;
      end
    end
  end

endmodule

// File: tb/tb_bram_march_checker.sv
// Self-checking bench for bram_march_checker (DATA_W=8, ADDR_W=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_bram_march_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       inject_en = 1'b0;
  logic [3:0] inject_addr = 4'd0;
  logic       busy, done, pass;
  logic [15:0] err_count;
  logic [3:0] fail_addr;
  logic [7:0] leds;

  always #5 clk = ~clk;

  bram_march_checker #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .inject_en   (inject_en),
    .inject_addr (inject_addr),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .fail_addr   (fail_addr),
    .leds        (leds)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int edge0   = 0;
  int done_e  = -1;
  int cmp_e   = 0;
  bit trk     = 1'b0;

  // Behavioural model state: memory image and expected run results.
  logic [7:0] mm [16];
  int m_err, m_fail, m_lat, m_inj;
  bit m_armed;
  logic [7:0] exp_leds;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] tpat(input int md, input int a);
    if (md == 0) return 8'hAA;
    if (md == 1) return (a % 2 == 0) ? 8'hAA : 8'h55;
    return 8'(a);
  endfunction

  task automatic mw(input int a, input logic [7:0] v);
    logic [7:0] x;
    x = v;
    if (m_armed && a == m_inj) begin
      x[0] = ~x[0];
      m_armed = 1'b0;
    end
    mm[a] = x;
  endtask

  task automatic mr(input int a, input logic [7:0] e);
    if (mm[a] !== e) begin
      if (m_err == 0) m_fail = a;
      m_err++;
    end
  endtask

  // Whole-run model: apply the test's write/read sequence to an array.
  task automatic model_run(input int md, input bit ie, input int ia);
    m_err = 0; m_fail = 0; m_armed = ie; m_inj = ia;
    if (md != 3) begin
      for (int a = 0; a < 16; a++) mw(a, tpat(md, a));
      for (int a = 0; a < 16; a++) mr(a, tpat(md, a));
      m_lat = 2 * 16 + 2;
    end else begin
      for (int a = 0; a < 16; a++) mw(a, 8'h00);
      for (int a = 0; a < 16; a++) begin mr(a, 8'h00); mw(a, 8'hFF); end
      for (int a = 0; a < 16; a++) begin mr(a, 8'hFF); mw(a, 8'h00); end
      for (int a = 15; a >= 0; a--) begin mr(a, 8'h00); mw(a, 8'hFF); end
      for (int a = 15; a >= 0; a--) begin mr(a, 8'hFF); mw(a, 8'h00); end
      for (int a = 0; a < 16; a++) mr(a, 8'h00);
      m_lat = 10 * 16 + 2;
    end
  endtask

  // Per-cycle compare of the running DUT against the model's timeline and results.
  always @(negedge clk) begin
    if (trk && cyc >= edge0) begin
      cmp_e = cyc - edge0 + 1;
      if (done) done_e = cmp_e;
      chk("busy", 32'(busy), 32'(cmp_e < m_lat));
      chk("done", 32'(done), 32'(cmp_e == m_lat));
      chk("leds_busy", 32'(leds[7]), 32'(cmp_e < m_lat));
      if (cmp_e < m_lat) begin
        chk("pass_cleared", 32'(pass), 0);
      end else begin
        exp_leds = {1'b0, m_err == 0, m_err != 0, (m_err > 31) ? 5'd31 : 5'(m_err)};
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("fail_addr", 32'(fail_addr), 32'(m_fail));
        chk("pass", 32'(pass), 32'(m_err == 0));
        chk("leds", 32'(leds), 32'(exp_leds));
        trk = 1'b0;
      end
    end
  end

  // Launch a run: start is sampled at edge0, then run inputs are scrambled.
  task automatic do_start(input int md, input bit ie, input int ia);
    model_run(md, ie, ia);
    @(posedge clk); #1;
    mode = 2'(md); inject_en = ie; inject_addr = 4'(ia);
    start = 1'b1; edge0 = cyc + 1; done_e = -1; trk = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    inject_en = 1'($urandom_range(0, 1));
    inject_addr = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_run();
    for (int i = 0; i < 400 && trk; i++) @(posedge clk);
    if (trk) begin
      n_tests++; n_fail++;
      $display("FAIL run_timeout: run still open after 400 cycles");
      trk = 1'b0;
    end
  endtask

  task automatic chk_final(input int lat, input int err, input int fa, input logic [7:0] ld);
    chk("done_edge", 32'(done_e), 32'(lat));
    chk("final_err", 32'(err_count), 32'(err));
    chk("final_fail_addr", 32'(fail_addr), 32'(fa));
    chk("final_leds", 32'(leds), 32'(ld));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_pass"}, 32'(pass), 0);
    chk({nm, "_err"}, 32'(err_count), 0);
    chk({nm, "_fail_addr"}, 32'(fail_addr), 0);
    chk({nm, "_leds"}, 32'(leds), 0);
  endtask

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    do_start(0, 1'b0, 0);  wait_run(); chk_final(34, 0, 0, 8'h40);
    do_start(2, 1'b1, 5);  wait_run(); chk_final(34, 1, 5, 8'h21);
    do_start(3, 1'b0, 0);  wait_run(); chk_final(162, 0, 0, 8'h40);
    do_start(3, 1'b1, 3);  wait_run(); chk_final(162, 1, 3, 8'h21);
    do_start(1, 1'b1, 15); wait_run(); chk_final(34, 1, 15, 8'h21);

    // Second start at edge 5 lands while busy and must change nothing.
    do_start(0, 1'b0, 0);
    repeat (4) @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_run(); chk_final(34, 0, 0, 8'h40);

    // Reset sampled at edge 10 aborts the run with no done pulse.
    do_start(0, 1'b0, 0);
    repeat (9) @(posedge clk); #1 reset = 1'b1; trk = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("midrun_reset");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("post_reset_no_done", 32'(done), 0);
    end

    do_start(0, 1'b0, 0); wait_run(); chk_final(34, 0, 0, 8'h40);

    // Random runs, with a stray start pulse while busy.
    for (int r = 0; r < 12; r++) begin
      do_start(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_run();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
